// File: rtl/histogram_compressor_if.sv
// Handshake and result bundle between a pair-stream producer and the histogram compressor.
// The master side drives the stream and reads back the latched bin counts.
interface histogram_compressor_if #(
  parameter int COUNTER_WIDTH = 8
);
  logic                     start_compress;
  logic                     stream_a;
  logic                     stream_b;
  logic                     valid_in;
  logic                     last_in;
  logic                     ready_in;
  logic [COUNTER_WIDTH-1:0] count_00;
  logic [COUNTER_WIDTH-1:0] count_01;
  logic [COUNTER_WIDTH-1:0] count_10;
  logic [COUNTER_WIDTH-1:0] count_11;
  logic [COUNTER_WIDTH-1:0] total_count;
  logic                     counts_valid;
  logic                     compress_done;

  modport master (
    output start_compress, stream_a, stream_b, valid_in, last_in,
    input  ready_in, count_00, count_01, count_10, count_11, total_count,
           counts_valid, compress_done
  );

  modport slave (
    input  start_compress, stream_a, stream_b, valid_in, last_in,
    output ready_in, count_00, count_01, count_10, count_11, total_count,
           counts_valid, compress_done
  );
endinterface

// File: rtl/histogram_compressor.sv
// Bins a pair of unary bitstreams into four occurrence counters (00/01/10/11) and
// latches the counts plus their total at end of stream for the downstream decompressor.
module histogram_compressor #(
  parameter int STREAM_LENGTH = 128,
  parameter int COUNTER_WIDTH = $clog2(STREAM_LENGTH + 1)
) (
  input logic                   clk,
  input logic                   rst,
  histogram_compressor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  localparam logic [COUNTER_WIDTH-1:0] LAST_TOTAL = COUNTER_WIDTH'(STREAM_LENGTH - 1);
  localparam logic [COUNTER_WIDTH-1:0] ONE        = COUNTER_WIDTH'(1);

  state_t                   state;
  state_t                   state_next;
  logic [COUNTER_WIDTH-1:0] bin [4];
  logic [COUNTER_WIDTH-1:0] total;
  logic [1:0]               sel;
  logic                     accept;
  logic                     run_start;

  assign sel          = {bus.stream_a, bus.stream_b};
  assign bus.ready_in = (state == COUNT);
  assign accept       = bus.valid_in && (state == COUNT);
  assign run_start    = (state == IDLE) && bus.start_compress;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A run ends on last_in (with or without a pair) or when the accepted pair fills the stream.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (bus.start_compress) state_next = COUNT;
      COUNT: begin
        if (bus.last_in)                        state_next = DONE;
        else if (accept && total == LAST_TOTAL) state_next = DONE;
      end
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || run_start) begin
      for (int i = 0; i < 4; i++) bin[i] <= '0;
      total <= '0;
    end else if (accept) begin
      bin[sel] <= bin[sel] + ONE;
      total    <= total + ONE;
    end
  end

  // Results change only on the edge leaving DONE, so they stay stable through the next run.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.count_00      <= '0;
      bus.count_01      <= '0;
      bus.count_10      <= '0;
      bus.count_11      <= '0;
      bus.total_count   <= '0;
      bus.counts_valid  <= 1'b0;
      bus.compress_done <= 1'b0;
    end else begin
      bus.compress_done <= (state == DONE);
      if (run_start) bus.counts_valid <= 1'b0;
      if (state == DONE) begin
        bus.count_00     <= bin[0];
        bus.count_01     <= bin[1];
        bus.count_10     <= bin[2];
        bus.count_11     <= bin[3];
        bus.total_count  <= total;
        bus.counts_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_histogram_compressor.sv
// Directed and randomized checks of histogram_compressor against a pair-histogram model.
module tb_histogram_compressor;
  localparam int SL = 128;
  localparam int CW = $clog2(SL + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  histogram_compressor_if #(.COUNTER_WIDTH(CW)) bus ();
  histogram_compressor #(.STREAM_LENGTH(SL), .COUNTER_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int done_seen = 0;
  int mc[4];
  int mtot;
  bit stopped;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dut_bin(input int i);
    case (i)
      0:       return 32'(bus.count_00);
      1:       return 32'(bus.count_01);
      2:       return 32'(bus.count_10);
      default: return 32'(bus.count_11);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.compress_done === 1'b1) done_seen++;
  endtask

  task automatic clear_inputs();
    bus.start_compress = 1'b0;
    bus.stream_a = 1'b0;
    bus.stream_b = 1'b0;
    bus.valid_in = 1'b0;
    bus.last_in = 1'b0;
  endtask

  task automatic begin_run(input string tag);
    for (int i = 0; i < 4; i++) mc[i] = 0;
    mtot = 0;
    stopped = 1'b0;
    done_seen = 0;
    bus.start_compress = 1'b1;
    step();
    bus.start_compress = 1'b0;
    chk({tag, "_ready"}, 32'(bus.ready_in), 1);
    chk({tag, "_cv_clr"}, 32'(bus.counts_valid), 0);
  endtask

  // Model: a run's result is the histogram of its pairs up to last_in or the SL-th pair.
  task automatic drive_pair(input string tag, input int idx, input bit last);
    if (stopped) chk({tag, "_ready_drop"}, 32'(bus.ready_in), 0);
    bus.valid_in = 1'b1;
    bus.stream_a = idx[1];
    bus.stream_b = idx[0];
    bus.last_in  = last;
    step();
    bus.valid_in = 1'b0;
    bus.last_in  = 1'b0;
    if (!stopped) begin
      mc[idx]++;
      mtot++;
      if (last || mtot == SL) stopped = 1'b1;
    end
  endtask

  task automatic gap(input int g, input bit poke);
    for (int i = 0; i < g; i++) begin
      if (poke && !stopped && $urandom_range(0, 1) == 1) bus.start_compress = 1'b1;
      step();
      bus.start_compress = 1'b0;
    end
  endtask

  task automatic last_only();
    bus.last_in = 1'b1;
    step();
    bus.last_in = 1'b0;
    stopped = 1'b1;
  endtask

  task automatic end_run(input string tag);
    logic [31:0] sum;
    for (int t = 0; t < 8 && done_seen == 0; t++) step();
    chk({tag, "_done_pulse"}, 32'(done_seen), 1);
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_bin%0d", tag, i), dut_bin(i), 32'(mc[i]));
      sum += dut_bin(i);
    end
    chk({tag, "_total"}, 32'(bus.total_count), 32'(mtot));
    chk({tag, "_sum"}, sum, 32'(bus.total_count));
    chk({tag, "_cv"}, 32'(bus.counts_valid), 1);
    step();
    chk({tag, "_done_low"}, 32'(bus.compress_done), 0);
    chk({tag, "_ready_idle"}, 32'(bus.ready_in), 0);
  endtask

  task automatic run_queue(input string tag, input int q[$], input int maxgap,
                           input bit use_last, input bit poke);
    begin_run(tag);
    for (int i = 0; i < q.size(); i++) begin
      if (!stopped) gap($urandom_range(0, maxgap), poke);
      drive_pair(tag, q[i], use_last && (i == q.size() - 1));
    end
    if (!stopped) last_only();
    end_run(tag);
  endtask

  function automatic void shuffle(ref int q[$]);
    for (int i = q.size() - 1; i > 0; i--) begin
      int j;
      int t;
      j = $urandom_range(0, i);
      t = q[i];
      q[i] = q[j];
      q[j] = t;
    end
  endfunction

  function automatic void fill(ref int q[$], input int n0, input int n1, input int n2,
                               input int n3);
    q.delete();
    for (int i = 0; i < n0; i++) q.push_back(0);
    for (int i = 0; i < n1; i++) q.push_back(1);
    for (int i = 0; i < n2; i++) q.push_back(2);
    for (int i = 0; i < n3; i++) q.push_back(3);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int q[$];
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_ready", 32'(bus.ready_in), 0);
    chk("rst_cv", 32'(bus.counts_valid), 0);
    chk("rst_done", 32'(bus.compress_done), 0);
    chk("rst_total", 32'(bus.total_count), 0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_bin%0d", i), dut_bin(i), 0);

    fill(q, 10, 0, 0, 0);
    run_queue("ten00", q, 0, 1'b1, 1'b0);

    fill(q, 0, 5, 7, 0);
    shuffle(q);
    run_queue("gaps", q, 3, 1'b1, 1'b0);

    fill(q, 0, 0, 0, SL + 1);
    run_queue("full", q, 0, 1'b0, 1'b0);

    begin_run("empty");
    last_only();
    end_run("empty");

    begin_run("abort");
    for (int i = 0; i < 6; i++) drive_pair("abort", int'($urandom_range(0, 3)), 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    done_seen = 0;
    chk("abort_cv", 32'(bus.counts_valid), 0);
    chk("abort_ready", 32'(bus.ready_in), 0);
    chk("abort_total", 32'(bus.total_count), 0);
    for (int i = 0; i < 4; i++) chk($sformatf("abort_bin%0d", i), dut_bin(i), 0);
    gap(3, 1'b0);
    chk("abort_no_done", 32'(done_seen), 0);

    fill(q, 20, 15, 12, 8);
    shuffle(q);
    run_queue("second", q, 2, 1'b1, 1'b1);

    fill(q, 4, 6, 2, 0);
    shuffle(q);
    run_queue("loopback", q, 1, 1'b1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(1, SL + 12);
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(int'($urandom_range(0, 3)));
      run_queue($sformatf("rand%0d", r), q, 3, 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/histogram_compressor.md
Name: histogram_compressor

Overview:
Upstream stage of histogram_decompressor. It consumes a pair of unary bitstreams (stream_a, stream_b), one bit-pair per accepted cycle, and bins every pair into four occurrence counters (00, 01, 10, 11). At end of stream it latches the four counts as the compressed representation; these feed count_00..count_11 of the decompressor directly.

Parameters:
STREAM_LENGTH, 128, maximum number of pairs in one stream; reaching it terminates the run
COUNTER_WIDTH, $clog2(STREAM_LENGTH+1), width of each bin count and of the total count

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start_compress  input  1  single-cycle pulse; begins a new run (honoured only in IDLE)
stream_a  input  1  bit of stream A for the current pair
stream_b  input  1  bit of stream B for the current pair
valid_in  input  1  current pair is valid
last_in  input  1  end-of-stream marker; with valid_in the pair is the last one; without valid_in the stream ends with no pair added
ready_in  output  1  block accepts pairs (high only in COUNT)
count_00  output  COUNTER_WIDTH  latched number of 00 pairs
count_01  output  COUNTER_WIDTH  latched number of 01 pairs
count_10  output  COUNTER_WIDTH  latched number of 10 pairs
count_11  output  COUNTER_WIDTH  latched number of 11 pairs
total_count  output  COUNTER_WIDTH  latched total pairs (sum of four bins)
counts_valid  output  1  level; latched counts belong to the last completed run
compress_done  output  1  one-cycle pulse when counts are latched

Behaviour:
- Reset (rst=1 at a clk edge, highest priority, any state): state IDLE; internal bins and total 0; all count outputs 0; ready_in, counts_valid, compress_done 0.
- States: IDLE, COUNT, DONE. Registered state; ready_in = (state==COUNT), decoded from state.
- IDLE: start_compress=1 -> clear internal bins/total, clear counts_valid, go COUNT. Other inputs ignored. Output counts keep previous values.
- COUNT: accept when valid_in && ready_in; increment bin selected by {stream_a,stream_b} and total at that edge.
- Termination in COUNT: (a) valid_in && last_in -> pair counted, go DONE; (b) last_in without valid_in -> nothing counted, go DONE; (c) accepted pair makes total == STREAM_LENGTH -> go DONE regardless of last_in. Otherwise stay in COUNT (idle cycles with valid_in=0 allowed, no timeout).
- start_compress during COUNT or DONE: ignored.
- DONE (exactly one cycle): at the edge leaving DONE copy bins/total to outputs, set counts_valid=1, pulse compress_done=1 for one cycle; return IDLE. valid_in in DONE/IDLE is dropped and never counted.
- Latency: terminating event sampled at edge k -> DONE during cycle k..k+1 -> counts and compress_done visible after edge k+1; compress_done low again after edge k+2.
- Width: bins never exceed STREAM_LENGTH (run ends at total==STREAM_LENGTH), so no saturation logic; COUNTER_WIDTH holds STREAM_LENGTH exactly. Invariant: count_00+count_01+count_10+count_11 == total_count.
- Reset mid-COUNT: run discarded, outputs return to 0, counts_valid 0, no compress_done.
- Back-to-back: start_compress in the cycle after compress_done starts a new run normally.

Test Plan:
- start, 10 pairs 00, last on 10th -> after done: count_00=10, others 0, total_count=12'd? no: total_count=10, compress_done one cycle, counts_valid=1.
- start, 5x01 and 7x10 interleaved with valid_in gaps of 0-3 cycles, last on final pair -> 00=0, 01=5, 10=7, 11=0, total=12; gap cycles add nothing.
- start, 128 pairs of 11 with last_in never asserted, then a 129th valid pair -> count_11=128, total=128, done after pair 128; 129th ignored (ready_in=0).
- start, then last_in=1 with valid_in=0 -> all counts 0, total 0, compress_done pulses, counts_valid=1.
- start, 6 pairs, rst=1 for one cycle, start again, 20x00/15x01/12x10/8x11 then last -> only second run reported (20,15,12,8, total 55); start_compress pulsed mid-run has no effect.
- Loopback: feed outputs into histogram_decompressor for histogram (4,6,2,0), re-compress its stream_a/stream_b -> identical counts 4,6,2,0.
